muldiv_issue: RTL and testbench
===============================

MULDIV_ISSUE -- requirements
Module: muldiv_issue

Interface
REQ-001 SHALL have one clock and a synchronous, active-low reset; port names Clk and Reset_n.
REQ-002 Clk  in  1  rising-edge clock for all state.
REQ-003 Reset_n  in  1  synchronous active-low reset, sampled on the Clk rising edge.
REQ-004 op_valid  in  1  pipeline presents an M-extension op in EX.
REQ-005 funct3  in  3  0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
REQ-006 rs1, rs2  in  32 each  source operands; held stable by the pipeline while pipe_stall=1.
REQ-007 pipe_stall  out  1  freezes the pipeline.
REQ-008 rd_data  out  32  result; valid only while rd_valid=1.
REQ-009 rd_valid  out  1  one-cycle result strobe.
REQ-010 mu_execute  out  1  start pulse to the iterative unsigned mul/div unit.
REQ-011 mu_div  out  1  1 = divide, 0 = multiply.
REQ-012 mu_a, mu_b  out  32 each  unsigned operand magnitudes to the unit.
REQ-013 mu_ready  in  1  unit result valid; held by the unit while mu_stall=1.
REQ-014 mu_result  in  64  unsigned product {hi,lo}, or {remainder, quotient} for divide.
REQ-015 mu_stall  out  1  holds the unit in its done state until the result is captured.

Function
REQ-016 States SHALL be IDLE, ISSUE, WAIT, FIXUP, RESP.
REQ-017 IDLE transitions:
- op_valid=0: stay in IDLE.
- op_valid=1 with a special divide: go to RESP.
- op_valid=1 otherwise: go to ISSUE.
- Operands, funct3 and the sign flags SHALL be latched on this edge.
REQ-018 Special divide cases SHALL bypass the unit.
- Divisor 0: DIV/DIVU give 0xFFFFFFFF; REM/REMU give rs1.
- DIV with rs1=0x80000000, rs2=0xFFFFFFFF: result 0x80000000.
- REM with the same operands: result 0.
REQ-019 Signedness per op:
- rs1 signed for MUL, MULH, MULHSU, DIV, REM.
- rs2 signed for MUL, MULH, DIV, REM.
- Magnitude = two's-complement negate if signed and bit31=1; 0x80000000 maps to 0x80000000.
REQ-020 ISSUE SHALL assert mu_execute=1 for exactly one cycle, with mu_a/mu_b/mu_div valid, then go to WAIT.
REQ-021 WAIT SHALL remain until mu_ready=1, capture mu_result on that edge, then go to FIXUP.
REQ-022 mu_stall SHALL be 1 in ISSUE and WAIT, except 0 in the WAIT cycle where mu_ready=1; it SHALL be 0 in all other states.
REQ-023 FIXUP sign correction:
- Multiply: negate the 64-bit product if the effective operand signs differ.
- Quotient: negate if the signs differ and the divisor is nonzero.
- Remainder: negate if the dividend is negative.
REQ-024 FIXUP result selection:
- MUL: low word.
- MULH/MULHSU/MULHU: high word.
- DIV/DIVU: quotient.
- REM/REMU: remainder.
REQ-025 RESP SHALL drive rd_valid=1, pipe_stall=0 and registered rd_data for one cycle, then go to IDLE.
REQ-026 pipe_stall SHALL be 1 combinationally in IDLE when op_valid=1, and 1 in ISSUE, WAIT and FIXUP.
REQ-027 Latency: rd_valid SHALL occur 2 cycles after the mu_ready capture edge; special cases SHALL give rd_valid 1 cycle after acceptance.
REQ-028 op_valid SHALL be ignored outside IDLE; a new op can be accepted the cycle after RESP (back-to-back).
REQ-029 mu_execute SHALL be 0 in every state except ISSUE.

Reset
REQ-030 While Reset_n=0 at a Clk edge: state=IDLE, and all outputs except pipe_stall SHALL be 0 (rd_data, rd_valid, mu_execute, mu_div, mu_a, mu_b, mu_stall); pipe_stall SHALL be 0 while op_valid=0.
REQ-031 Reset mid-operation SHALL abandon the op with no rd_valid; mu_stall=0 SHALL release the unit back to its idle state.

Verification
REQ-032 MUL rs1=0xFFFFFFFD (-3), rs2=7 -> mu_a=3, mu_b=7 -> rd_data=0xFFFFFFEB, rd_valid 2 cycles after mu_ready.
REQ-033 MULH rs1=0x80000000, rs2=0x80000000 -> rd_data=0x40000000; MULHSU with the same operands -> 0xC0000000.
REQ-034 DIV rs1=-7, rs2=2 -> 0xFFFFFFFD; REM with the same operands -> 0xFFFFFFFF; REMU rs1=7, rs2=2 -> 1.
REQ-035 DIVU rs2=0 -> 0xFFFFFFFF; DIV 0x80000000/-1 -> 0x80000000; mu_execute never asserted; rd_valid on cycle 2.
REQ-036 Back-to-back ops with op_valid held across RESP -> two rd_valid pulses and two mu_execute pulses, none dropped or duplicated.
REQ-037 Reset_n=0 during WAIT -> next cycle IDLE, mu_stall=0, no rd_valid; a subsequent MULHU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFE.

Source files
------------

// File: rtl/muldiv_issue_if.sv
// Bundles the pipeline-side and unit-side signals of the M-extension issue
// logic. The issue block takes the slave view; its environment (pipeline plus
// the iterative mul/div unit) takes the master view.
interface muldiv_issue_if;
    // pipeline side
    logic        op_valid;
    logic [2:0]  funct3;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic        pipe_stall;
    logic [31:0] rd_data;
    logic        rd_valid;
    // iterative unsigned mul/div unit side
    logic        mu_execute;
    logic        mu_div;
    logic [31:0] mu_a;
    logic [31:0] mu_b;
    logic        mu_ready;
    logic [63:0] mu_result;
    logic        mu_stall;

    modport slave (
        input  op_valid, funct3, rs1, rs2, mu_ready, mu_result,
        output pipe_stall, rd_data, rd_valid,
        output mu_execute, mu_div, mu_a, mu_b, mu_stall
    );

    modport master (
        output op_valid, funct3, rs1, rs2, mu_ready, mu_result,
        input  pipe_stall, rd_data, rd_valid,
        input  mu_execute, mu_div, mu_a, mu_b, mu_stall
    );
endinterface

// File: rtl/muldiv_issue.sv
// Issue/fix-up wrapper around an iterative unsigned mul/div unit. Converts
// signed RISC-V M-extension operands to magnitudes, handles the divide corner
// cases locally, and applies sign correction to the unsigned result.
module muldiv_issue (
    input  logic           Clk,
    input  logic           Reset_n,
    muldiv_issue_if.slave  bus
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ISSUE = 3'd1,
        WAIT  = 3'd2,
        FIXUP = 3'd3,
        RESP  = 3'd4
    } state_t;

    state_t      state_r;
    state_t      next_state_s;

    logic [2:0]  funct3_r;
    logic        neg_a_r;
    logic        neg_b_r;
    logic        mu_div_r;
    logic [31:0] mu_a_r;
    logic [31:0] mu_b_r;
    logic [63:0] res_r;
    logic [31:0] rd_data_r;

    logic        a_signed_s;
    logic        b_signed_s;
    logic        neg_a_s;
    logic        neg_b_s;
    logic        div_zero_s;
    logic        div_ovf_s;
    logic        special_s;
    logic [31:0] special_result_s;
    logic [63:0] product_s;
    logic [31:0] quot_s;
    logic [31:0] rem_s;
    logic [31:0] fixup_result_s;
    logic        mu_execute_s;
    logic        mu_stall_s;
    logic        pipe_stall_s;
    logic        rd_valid_s;

    // Two's-complement magnitude; 0x80000000 stays 0x80000000 naturally.
    function automatic logic [31:0] magnitude(input logic [31:0] x, input logic neg);
        return neg ? (~x + 32'd1) : x;
    endfunction

    // Signedness, special-case detection and bypass result from live operands.
    always_comb begin
        a_signed_s = (bus.funct3 != 3'd3) && (bus.funct3 != 3'd5) && (bus.funct3 != 3'd7);
        b_signed_s = (bus.funct3 == 3'd0) || (bus.funct3 == 3'd1) ||
                     (bus.funct3 == 3'd4) || (bus.funct3 == 3'd6);
        neg_a_s    = a_signed_s && bus.rs1[31];
        neg_b_s    = b_signed_s && bus.rs2[31];
        div_zero_s = bus.funct3[2] && (bus.rs2 == 32'd0);
        div_ovf_s  = ((bus.funct3 == 3'd4) || (bus.funct3 == 3'd6)) &&
                     (bus.rs1 == 32'h8000_0000) && (bus.rs2 == 32'hFFFF_FFFF);
        special_s  = div_zero_s || div_ovf_s;
        if (div_zero_s) begin
            special_result_s = bus.funct3[1] ? bus.rs1 : 32'hFFFF_FFFF;
        end else begin
            special_result_s = bus.funct3[1] ? 32'd0 : 32'h8000_0000;
        end
    end

    // Sign correction of the captured unit result and final word selection.
    always_comb begin
        product_s = (neg_a_r ^ neg_b_r) ? (~res_r + 64'd1) : res_r;
        quot_s    = (neg_a_r ^ neg_b_r) ? (~res_r[31:0] + 32'd1) : res_r[31:0];
        rem_s     = neg_a_r ? (~res_r[63:32] + 32'd1) : res_r[63:32];
        case (funct3_r)
            3'd0:                fixup_result_s = product_s[31:0];
            3'd1, 3'd2, 3'd3:    fixup_result_s = product_s[63:32];
            3'd4, 3'd5:          fixup_result_s = quot_s;
            3'd6, 3'd7:          fixup_result_s = rem_s;
            default:             fixup_result_s = 32'd0;
        endcase
    end

    // FSM state register.
    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // FSM next-state logic; op_valid only matters in IDLE.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            IDLE: begin
                if (bus.op_valid) begin
                    next_state_s = special_s ? RESP : ISSUE;
                end else begin
                    next_state_s = IDLE;
                end
            end
            ISSUE:   next_state_s = WAIT;
            WAIT: begin
                if (bus.mu_ready) begin
                    next_state_s = FIXUP;
                end else begin
                    next_state_s = WAIT;
                end
            end
            FIXUP:   next_state_s = RESP;
            RESP:    next_state_s = IDLE;
            default: next_state_s = IDLE;
        endcase
    end

    // FSM output decode; mu_stall drops in the WAIT cycle that sees mu_ready.
    always_comb begin
        mu_execute_s = 1'b0;
        mu_stall_s   = 1'b0;
        pipe_stall_s = 1'b0;
        rd_valid_s   = 1'b0;
        case (state_r)
            IDLE:  pipe_stall_s = bus.op_valid;
            ISSUE: begin
                mu_execute_s = 1'b1;
                mu_stall_s   = 1'b1;
                pipe_stall_s = 1'b1;
            end
            WAIT: begin
                mu_stall_s   = ~bus.mu_ready;
                pipe_stall_s = 1'b1;
            end
            FIXUP: pipe_stall_s = 1'b1;
            RESP:  rd_valid_s   = 1'b1;
            default: begin
                mu_execute_s = 1'b0;
                mu_stall_s   = 1'b0;
                pipe_stall_s = 1'b0;
                rd_valid_s   = 1'b0;
            end
        endcase
    end

    // Operand latch on acceptance, unit result capture, and result register.
    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            funct3_r  <= 3'd0;
            neg_a_r   <= 1'b0;
            neg_b_r   <= 1'b0;
            mu_div_r  <= 1'b0;
            mu_a_r    <= 32'd0;
            mu_b_r    <= 32'd0;
            res_r     <= 64'd0;
            rd_data_r <= 32'd0;
        end else begin
            if ((state_r == IDLE) && bus.op_valid) begin
                funct3_r <= bus.funct3;
                neg_a_r  <= neg_a_s;
                neg_b_r  <= neg_b_s;
                mu_div_r <= bus.funct3[2];
                mu_a_r   <= magnitude(bus.rs1, neg_a_s);
                mu_b_r   <= magnitude(bus.rs2, neg_b_s);
                if (special_s) begin
                    rd_data_r <= special_result_s;
                end
            end
            if ((state_r == WAIT) && bus.mu_ready) begin
                res_r <= bus.mu_result;
            end
            if (state_r == FIXUP) begin
                rd_data_r <= fixup_result_s;
            end
        end
    end

    assign bus.mu_execute = mu_execute_s;
    assign bus.mu_stall   = mu_stall_s;
    assign bus.pipe_stall = pipe_stall_s;
    assign bus.rd_valid   = rd_valid_s;
    assign bus.rd_data    = rd_data_r;
    assign bus.mu_div     = mu_div_r;
    assign bus.mu_a       = mu_a_r;
    assign bus.mu_b       = mu_b_r;

endmodule

// File: tb/tb_muldiv_issue.sv
// Directed bench for muldiv_issue with a small behavioural iterative unit.
module tb_muldiv_issue;

    logic clk;
    logic reset_n;
    int   check_cnt = 0;
    int   pass_cnt  = 0;
    int   unit_lat  = 3;

    muldiv_issue_if bus();

    muldiv_issue dut (
        .Clk     (clk),
        .Reset_n (reset_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural unsigned mul/div unit: result after unit_lat cycles,
    // held until mu_stall drops.
    logic        unit_busy;
    int          unit_cnt;
    always @(posedge clk) begin
        if (!reset_n) begin
            unit_busy     <= 1'b0;
            unit_cnt      <= 0;
            bus.mu_ready  <= 1'b0;
            bus.mu_result <= 64'd0;
        end else if (bus.mu_execute) begin
            unit_busy    <= 1'b1;
            unit_cnt     <= unit_lat;
            bus.mu_ready <= 1'b0;
            if (bus.mu_div) begin
                if (bus.mu_b == 32'd0) begin
                    bus.mu_result <= 64'd0;
                end else begin
                    bus.mu_result <= {bus.mu_a % bus.mu_b, bus.mu_a / bus.mu_b};
                end
            end else begin
                bus.mu_result <= {32'd0, bus.mu_a} * {32'd0, bus.mu_b};
            end
        end else if (bus.mu_ready) begin
            if (!bus.mu_stall) begin
                bus.mu_ready <= 1'b0;
                unit_busy    <= 1'b0;
            end
        end else if (unit_busy) begin
            if (unit_cnt > 0) begin
                unit_cnt <= unit_cnt - 1;
            end else begin
                bus.mu_ready <= 1'b1;
            end
        end
    end

    task automatic check_eq(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        check_cnt++;
        if (actual === expected) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    // Issue one op, follow it to completion and check result, latency and unit traffic.
    task automatic run_op(input string tag, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp_d,
                          input logic [31:0] exp_a, input logic [31:0] exp_b,
                          input bit special);
        int exec_cnt  = 0;
        int rv_cnt    = 0;
        int ready_cyc = -1;
        int rd_cyc    = -1;
        logic [31:0] got_d   = 32'd0;
        logic [31:0] got_a   = 32'd0;
        logic [31:0] got_b   = 32'd0;
        logic        got_div = 1'b0;
        @(negedge clk);
        bus.op_valid = 1'b1;
        bus.funct3   = f3;
        bus.rs1      = a;
        bus.rs2      = b;
        #1;
        check_eq({tag, " pipe_stall on accept"}, 64'(bus.pipe_stall), 64'd1);
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            bus.op_valid = 1'b0;
            if (bus.mu_execute) begin
                exec_cnt++;
                got_a   = bus.mu_a;
                got_b   = bus.mu_b;
                got_div = bus.mu_div;
            end
            if (bus.mu_ready && ready_cyc < 0) ready_cyc = c;
            if (bus.rd_valid) begin
                rv_cnt++;
                rd_cyc = c;
                got_d  = bus.rd_data;
            end
            if (rd_cyc > 0 && c >= rd_cyc + 3) break;
        end
        check_eq({tag, " rd_data"}, 64'(got_d), 64'(exp_d));
        check_eq({tag, " rd_valid pulses"}, 64'(rv_cnt), 64'd1);
        check_eq({tag, " mu_execute pulses"}, 64'(exec_cnt), special ? 64'd0 : 64'd1);
        if (special) begin
            check_eq({tag, " latency"}, 64'(rd_cyc), 64'd1);
        end else begin
            check_eq({tag, " latency"}, 64'(rd_cyc - ready_cyc), 64'd2);
            check_eq({tag, " mu_a"}, 64'(got_a), 64'(exp_a));
            check_eq({tag, " mu_b"}, 64'(got_b), 64'(exp_b));
            check_eq({tag, " mu_div"}, 64'(got_div), 64'(f3[2]));
        end
    endtask

    initial begin
        int exec_cnt;
        int rv_cnt;
        logic [31:0] d1;
        logic [31:0] d2;
        reset_n      = 1'b0;
        bus.op_valid = 1'b0;
        bus.funct3   = 3'd0;
        bus.rs1      = 32'd0;
        bus.rs2      = 32'd0;
        repeat (3) @(negedge clk);
        check_eq("reset rd_valid",   64'(bus.rd_valid),   64'd0);
        check_eq("reset rd_data",    64'(bus.rd_data),    64'd0);
        check_eq("reset mu_execute", 64'(bus.mu_execute), 64'd0);
        check_eq("reset mu_stall",   64'(bus.mu_stall),   64'd0);
        check_eq("reset mu_a",       64'(bus.mu_a),       64'd0);
        check_eq("reset mu_b",       64'(bus.mu_b),       64'd0);
        check_eq("reset mu_div",     64'(bus.mu_div),     64'd0);
        check_eq("reset pipe_stall", 64'(bus.pipe_stall), 64'd0);
        reset_n = 1'b1;
        @(negedge clk);

        run_op("MUL -3*7",        3'd0, 32'hFFFF_FFFD, 32'd7,        32'hFFFF_FFEB, 32'd3,        32'd7,        1'b0);
        run_op("MULH min*min",    3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h8000_0000, 32'h8000_0000, 1'b0);
        run_op("MULHSU min*2^31", 3'd2, 32'h8000_0000, 32'h8000_0000, 32'hC000_0000, 32'h8000_0000, 32'h8000_0000, 1'b0);
        run_op("DIV -7/2",        3'd4, 32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFD, 32'd7,        32'd2,        1'b0);
        run_op("REM -7%2",        3'd6, 32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, 32'd7,        32'd2,        1'b0);
        run_op("REMU 7%2",        3'd7, 32'd7,         32'd2,        32'd1,         32'd7,        32'd2,        1'b0);
        run_op("DIVU by 0",       3'd5, 32'd1234,      32'd0,        32'hFFFF_FFFF, 32'd0,        32'd0,        1'b1);
        run_op("DIV ovf",         3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0,        32'd0,        1'b1);
        run_op("REM by 0",        3'd6, 32'h1234_5678, 32'd0,        32'h1234_5678, 32'd0,        32'd0,        1'b1);
        run_op("REM ovf",         3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         32'd0,        32'd0,        1'b1);

        // Back-to-back: op_valid held across RESP, second op presented in RESP.
        exec_cnt = 0;
        rv_cnt   = 0;
        d1       = 32'd0;
        d2       = 32'd0;
        @(negedge clk);
        bus.op_valid = 1'b1;
        bus.funct3   = 3'd0;
        bus.rs1      = 32'd6;
        bus.rs2      = 32'd7;
        for (int c = 1; c <= 80; c++) begin
            @(negedge clk);
            if (bus.mu_execute) exec_cnt++;
            if (bus.rd_valid) begin
                rv_cnt++;
                if (rv_cnt == 1) begin
                    d1         = bus.rd_data;
                    bus.funct3 = 3'd5;
                    bus.rs1    = 32'd100;
                    bus.rs2    = 32'd7;
                end else begin
                    d2           = bus.rd_data;
                    bus.op_valid = 1'b0;
                end
            end
            if (rv_cnt >= 2 && !bus.op_valid && c > 60) break;
        end
        check_eq("b2b rd_valid pulses",   64'(rv_cnt),   64'd2);
        check_eq("b2b mu_execute pulses", 64'(exec_cnt), 64'd2);
        check_eq("b2b first result",      64'(d1),       64'd42);
        check_eq("b2b second result",     64'(d2),       64'd14);

        // Reset while waiting on the unit.
        unit_lat = 6;
        @(negedge clk);
        bus.op_valid = 1'b1;
        bus.funct3   = 3'd0;
        bus.rs1      = 32'd5;
        bus.rs2      = 32'd6;
        exec_cnt = 0;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            bus.op_valid = 1'b0;
            if (bus.mu_execute) begin
                exec_cnt++;
                break;
            end
        end
        check_eq("abort op issued", 64'(exec_cnt), 64'd1);
        @(negedge clk);
        check_eq("abort in WAIT mu_stall", 64'(bus.mu_stall), 64'd1);
        reset_n = 1'b0;
        @(negedge clk);
        check_eq("abort mu_stall",   64'(bus.mu_stall),   64'd0);
        check_eq("abort rd_valid",   64'(bus.rd_valid),   64'd0);
        check_eq("abort mu_execute", 64'(bus.mu_execute), 64'd0);
        check_eq("abort pipe_stall", 64'(bus.pipe_stall), 64'd0);
        check_eq("abort mu_a",       64'(bus.mu_a),       64'd0);
        reset_n = 1'b1;
        rv_cnt  = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (bus.rd_valid) rv_cnt++;
        end
        check_eq("abort no rd_valid", 64'(rv_cnt), 64'd0);
        unit_lat = 3;
        run_op("MULHU max*max", 3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE,
               32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);

        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule
